crf_axil_master: RTL and testbench
==================================

// Module: crf_axil_master
// PURPOSE
//  AXI4-Lite initiator that drives the config register file's lite slave from a simple command/response port.
//  Used by the host-side test harness and SoC glue to program start, end and handshake-count registers and to poll status.
//  Issues one single-beat transaction at a time: write (AW+W then B) or read (AR then R).
//  Sits between a command source (sequencer/CPU bridge) and the accelerator's lite slave port.
// PARAMETERS
//  AXI_DATA_WIDTH  32    lite data width; strobe width = AXI_DATA_WIDTH/8
//  AXI_ADDR_WIDTH  32    lite address width
//  TIMEOUT_CYCLES  1024  cycles waiting on the slave before tmo_err pulses; 0 disables the watchdog
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    asynchronous active-low reset
//  cmd_valid      in   1    command request
//  cmd_ready      out  1    command accepted when cmd_valid & cmd_ready
//  cmd_wr         in   1    1 = write, 0 = read
//  cmd_addr       in   AW   byte address
//  cmd_wdata      in   DW   write data
//  cmd_wstrb      in   DW/8 write strobes
//  rsp_valid      out  1    response available
//  rsp_ready      in   1    response consumed
//  rsp_wr         out  1    response belongs to a write
//  rsp_rdata      out  DW   read data; 0 for writes
//  rsp_resp       out  2    BRESP or RRESP as returned
//  tmo_err        out  1    one-cycle pulse when the watchdog expires
//  m_axi_aw*      out       awvalid, awaddr[AW], awprot[3]=3'b000; awready in
//  m_axi_w*       out       wvalid, wdata[DW], wstrb[DW/8]; wready in
//  m_axi_b*                 bvalid, bresp[2] in; bready out
//  m_axi_ar*      out       arvalid, araddr[AW], arprot[3]=3'b000; arready in
//  m_axi_r*                 rvalid, rdata[DW], rresp[2] in; rready out
// BEHAVIOUR
//  Reset: state IDLE; every valid/ready output 0 except cmd_ready=1; addr/data/strb/rsp_* outputs 0; watchdog counter 0.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE: cmd_ready=1. On accept, latch addr/data/strb/wr. Go to WR_REQ (wr) or RD_REQ (rd).
//    awvalid/wvalid, or arvalid, are registered and rise the cycle after accept.
//  WR_REQ: awvalid and wvalid are raised together. Each drops independently the cycle after its own handshake.
//    Handshakes may occur in either order or in the same cycle.
//    When both are done, go to WR_RESP. bready rises on entry to WR_RESP, never earlier.
//  WR_RESP: bready=1. On bvalid, capture bresp, set rsp_wr=1, rsp_rdata=0, go to RSP.
//  RD_REQ: arvalid=1 until arready, then RD_RESP with rready=1.
//  RD_RESP: on rvalid, capture rdata and rresp, set rsp_wr=0, go to RSP.
//  RSP: rsp_valid=1; outputs are held stable until rsp_ready. Then return to IDLE; cmd_ready rises the next cycle.
//  Minimum turnaround with a zero-wait slave: write = 4 cycles from accept to rsp_valid; read = 3 cycles.
//  AXI rules: a valid never drops before its handshake. Payload is stable while valid is high.
//    No combinational path from any input to any AXI output.
//  Watchdog: counts cycles in WR_REQ/WR_RESP/RD_REQ/RD_RESP and clears on every state change.
//    At TIMEOUT_CYCLES it pulses tmo_err once and saturates; the transaction is NOT aborted.
//  A bvalid/rvalid arriving outside its wait state is ignored, because bready/rready are 0.
//  rsp_resp is passed through unmodified; SLVERR/DECERR are reported, not retried.
//  Reset asserted mid-transaction: immediate return to reset values; the in-flight transfer is dropped.
// STRUCTURE
//  Shared package ac_pkg: axil_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), FSM state enum, CRF register byte offsets.
//  No sub-module: single FSM plus capture registers and watchdog counter.
// TESTING
//  Write 0x10=0x0000_0001, strb 0xF, zero-wait slave -> AW/W in one cycle, bready next cycle; rsp_valid 4 cycles after accept, rsp_wr=1, rsp_resp=0.
//  Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid is held 4 cycles; bready only after both handshakes.
//  Read 0x14, slave returns 0xDEAD_BEEF with rresp=2 -> rsp_rdata=0xDEADBEEF, rsp_resp=2, rsp_wr=0.
//  rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout; next command is accepted only after release.
//  TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> tmo_err pulses once at cycle 8; the response still completes normally.
//  rst_n pulsed low during WR_RESP -> all valids and bready are 0 asynchronously; cmd_ready=1 after release; a new read completes cleanly.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the config register file (CRF) AXI4-Lite path.
//   axil_resp_e   : AXI4-Lite BRESP/RRESP encodings
//   crf_state_t   : state encoding of crf_axil_master, as plain localparam constants
//   CRF_*_OFS     : byte offsets of the CRF registers on the lite slave
package ac_pkg;

   typedef enum logic [1:0] {
      AXIL_OKAY   = 2'd0,
      AXIL_EXOKAY = 2'd1,
      AXIL_SLVERR = 2'd2,
      AXIL_DECERR = 2'd3
   } axil_resp_e;

   typedef logic [2:0] crf_state_t;

   localparam crf_state_t ST_IDLE    = 3'd0;
   localparam crf_state_t ST_WR_REQ  = 3'd1;
   localparam crf_state_t ST_WR_RESP = 3'd2;
   localparam crf_state_t ST_RD_REQ  = 3'd3;
   localparam crf_state_t ST_RD_RESP = 3'd4;
   localparam crf_state_t ST_RSP     = 3'd5;

   localparam logic [31:0] CRF_CTRL_OFS     = 32'h0000_0000;
   localparam logic [31:0] CRF_STATUS_OFS   = 32'h0000_0004;
   localparam logic [31:0] CRF_START_OFS    = 32'h0000_0010;
   localparam logic [31:0] CRF_END_OFS      = 32'h0000_0014;
   localparam logic [31:0] CRF_HS_COUNT_OFS = 32'h0000_0018;
   localparam logic [31:0] CRF_SCRATCH_OFS  = 32'h0000_001C;

endpackage

// File: rtl/crf_axil_master.sv
// AXI4-Lite initiator for the CRF lite slave. Takes one command at a time from a
// valid/ready command port, runs a single-beat write (AW+W, then B) or read (AR, then R),
// and presents the result on a valid/ready response port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb payload
//   rsp_valid/rsp_ready        response handshake; rsp_wr, rsp_rdata, rsp_resp payload
//   tmo_err                    one-cycle pulse when the slave has stalled TIMEOUT_CYCLES cycles
//   m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
// All AXI outputs are registers or decodes of the state register.
module crf_axil_master
   import ac_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   // command port
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_wr,
   input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response port
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_wr,
   output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          tmo_err,
   // AXI4-Lite master
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp
);

   localparam int unsigned SW   = AXI_DATA_WIDTH / 8;
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

   crf_state_t state_q, state_d;

   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q,  wvalid_d;
   logic                      arvalid_q, arvalid_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
   logic [SW-1:0]             wstrb_q,   wstrb_d;
   logic                      rsp_wr_q,  rsp_wr_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic [1:0]                resp_q,    resp_d;
   logic [WD_W-1:0]           wd_q,      wd_d;
   logic                      tmo_q,     tmo_d;
   logic                      wait_st;

   // Next-state and capture logic
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rsp_wr_d  = rsp_wr_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               if (cmd_wr) begin
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            // Both valids start high in this state, so both low means both handshakes are
            // done; moving on from the registered flags keeps bready off until then.
            if (!awvalid_q && !wvalid_q) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (m_axi_bvalid) begin
               rsp_wr_d = 1'b1;
               rdata_d  = '0;
               resp_d   = m_axi_bresp;
               state_d  = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (m_axi_rvalid) begin
               rsp_wr_d = 1'b0;
               rdata_d  = m_axi_rdata;
               resp_d   = m_axi_rresp;
               state_d  = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Watchdog: counts cycles spent in one slave-wait state, saturating at TIMEOUT_CYCLES.
   // It only reports; the transaction keeps waiting.
   assign wait_st = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

   always_comb begin
      wd_d  = wd_q;
      tmo_d = 1'b0;
      if (!wait_st || (state_d != state_q)) begin
         wd_d = '0;
      end else if (wd_q != WD_MAX) begin
         wd_d = wd_q + WD_ONE;
      end
      tmo_d = (TIMEOUT_CYCLES != 0) && wait_st && (state_d == state_q) &&
              (wd_q == WD_MAX - WD_ONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_wr_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         wd_q      <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rsp_wr_q  <= rsp_wr_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         wd_q      <= wd_d;
         tmo_q     <= tmo_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign rsp_valid     = (state_q == ST_RSP);
   assign rsp_wr        = rsp_wr_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign tmo_err       = tmo_q;

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = (state_q == ST_WR_RESP);
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state_q == ST_RD_RESP);

endmodule

// File: tb/tb_crf_axil_master.sv
// Directed bench for crf_axil_master. The slave side is driven cycle by cycle from a
// single initial block; outputs are sampled 2 time units after each rising edge.
module tb_crf_axil_master;
   import ac_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic            clk;
   logic            rst_n;
   logic            cmd_valid, cmd_ready, cmd_wr;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [DW/8-1:0] cmd_wstrb;
   logic            rsp_valid, rsp_ready, rsp_wr;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            tmo_err;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [AW-1:0]   awaddr, araddr;
   logic [2:0]      awprot, arprot;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]      bresp, rresp;

   int n_checks = 0;
   int n_fail   = 0;
   int tmo_cnt  = 0;

   crf_axil_master #(
      .AXI_DATA_WIDTH (DW),
      .AXI_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_wr        (cmd_wr),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_wr        (rsp_wr),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .tmo_err       (tmo_err),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_awaddr  (awaddr),
      .m_axi_awprot  (awprot),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_wdata   (wdata),
      .m_axi_wstrb   (wstrb),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready),
      .m_axi_bresp   (bresp),
      .m_axi_arvalid (arvalid),
      .m_axi_arready (arready),
      .m_axi_araddr  (araddr),
      .m_axi_arprot  (arprot),
      .m_axi_rvalid  (rvalid),
      .m_axi_rready  (rready),
      .m_axi_rdata   (rdata),
      .m_axi_rresp   (rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, required finish before 200000");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst_n = 1'b1;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      #3 rst_n = 1'b0;
      #4;
      // ---- reset values
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, tmo_err}, 0);
      chk("rst_payload", {awaddr, araddr, wdata, wstrb, awprot, arprot}, 0);
      chk("rst_rsp", {rsp_wr, rsp_rdata, rsp_resp}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- write 0x10 = 1, zero-wait slave
      awready = 1'b1; wready = 1'b1;
      send(1'b1, CRF_START_OFS, 32'h0000_0001, 4'hF);
      tick();                                   // cycle 1 after accept
      cmd_valid = 1'b0;
      chk("w1_c1_valids", {awvalid, wvalid, bready, cmd_ready}, 4'b1100);
      chk("w1_c1_awaddr", awaddr, 32'h10);
      chk("w1_c1_wdata", {wdata, wstrb}, {32'h1, 4'hF});
      tick();                                   // cycle 2
      chk("w1_c2_valids", {awvalid, wvalid, bready}, 3'b000);
      bvalid = 1'b1; bresp = AXIL_OKAY;
      tick();                                   // cycle 3
      chk("w1_c3_bready", {bready, rsp_valid}, 2'b10);
      tick();                                   // cycle 4
      bvalid = 1'b0;
      chk("w1_c4_rsp", {rsp_valid, rsp_wr, rsp_resp, bready}, 5'b1_1_00_0);
      chk("w1_c4_rdata", rsp_rdata, 0);
      tick();
      chk("w1_idle", {cmd_ready, rsp_valid}, 2'b10);

      // ---- write with awready held off 3 cycles, wready immediate
      awready = 1'b0; wready = 1'b1;
      send(1'b1, CRF_HS_COUNT_OFS, 32'hA5A5_0003, 4'h3);
      tick();                                   // cycle 1
      cmd_valid = 1'b0;
      chk("w2_c1", {awvalid, wvalid}, 2'b11);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk($sformatf("w2_c%0d", i), {awvalid, wvalid, bready}, 3'b100);
         chk($sformatf("w2_c%0d_awaddr", i), awaddr, 32'h18);
      end
      awready = 1'b1;                           // handshake at end of cycle 4
      tick();                                   // cycle 5
      chk("w2_c5", {awvalid, wvalid, bready}, 3'b000);
      bvalid = 1'b1; bresp = AXIL_SLVERR;
      tick();
      chk("w2_bready", bready, 1);
      tick();
      bvalid = 1'b0;
      chk("w2_rsp", {rsp_valid, rsp_wr, rsp_resp}, 4'b1_1_10);
      tick();
      chk("w2_idle", cmd_ready, 1);

      // ---- read 0x14 returning DEADBEEF/SLVERR, response held 5 cycles
      arready = 1'b1; rsp_ready = 1'b0;
      send(1'b0, CRF_END_OFS, 32'h0, 4'h0);
      tick();                                   // cycle 1
      cmd_valid = 1'b0;
      chk("r1_c1", {arvalid, rready, awvalid, wvalid}, 4'b1000);
      chk("r1_araddr", araddr, 32'h14);
      tick();                                   // cycle 2
      chk("r1_c2", {arvalid, rready}, 2'b01);
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = AXIL_SLVERR;
      tick();                                   // cycle 3
      // Next command and a stray R beat while the response is held.
      send(1'b0, CRF_STATUS_OFS, 32'h0, 4'h0);
      rdata = 32'h1234_5678; rresp = AXIL_OKAY;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("r1_hold%0d_ctl", i), {rsp_valid, cmd_ready, rsp_wr, rready, arvalid},
             5'b10000);
         chk($sformatf("r1_hold%0d_data", i), {rsp_rdata, rsp_resp}, {32'hDEAD_BEEF, 2'b10});
         if (i == 4) rsp_ready = 1'b1;
         tick();
      end
      rvalid = 1'b0;
      chk("r2_accept", {cmd_ready, rsp_valid}, 2'b10);
      tick();
      cmd_valid = 1'b0;
      chk("r2_c1", {arvalid, araddr}, {1'b1, 32'h4});
      tick();
      rvalid = 1'b1; rdata = 32'h0000_00C3; rresp = AXIL_OKAY;
      tick();
      rvalid = 1'b0;
      chk("r2_rsp", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'hC3});
      tick();

      // ---- watchdog: bvalid withheld 20 cycles in WR_RESP
      awready = 1'b1; wready = 1'b1;
      send(1'b1, CRF_SCRATCH_OFS, 32'h0000_BEEF, 4'hF);
      tick();
      cmd_valid = 1'b0;
      chk("t_c1_tmo", tmo_err, 0);
      tick();
      chk("t_c2_tmo", tmo_err, 0);
      tick();                                   // first WR_RESP cycle
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t_wait%0d_tmo", i), tmo_err, (i == 8) ? 1 : 0);
         if (tmo_err) tmo_cnt++;
         if (i == 19) begin
            bvalid = 1'b1; bresp = AXIL_OKAY;
         end
         tick();
      end
      bvalid = 1'b0;
      chk("t_rsp", {rsp_valid, rsp_wr, rsp_resp, tmo_err}, 5'b1_1_00_0);
      chk("t_pulses", tmo_cnt, 1);
      tick();

      // ---- reset pulsed during WR_RESP
      send(1'b1, CRF_CTRL_OFS, 32'h0000_0007, 4'hF);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("x_bready_pre", bready, 1);
      rst_n = 1'b0;
      #1;
      chk("x_async", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      chk("x_cmd_ready", cmd_ready, 1);
      bvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("x_idle", {cmd_ready, bready, rsp_valid}, 3'b100);
      bvalid = 1'b0;
      send(1'b0, CRF_START_OFS, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      chk("x_rd_c1", {arvalid, araddr}, {1'b1, 32'h10});
      tick();
      rvalid = 1'b1; rdata = 32'h0000_0001; rresp = AXIL_OKAY;
      tick();
      rvalid = 1'b0;
      chk("x_rd_rsp", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h1});
      tick();
      chk("x_rd_idle", cmd_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
